pc_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit CPU: owns the program counter, drives the instruction-memory address, and registers the IF/ID pipeline latch. Sits directly upstream of the ID-stage branch comparator and consumes that comparator's `PCSrc` decision plus the branch/jump target. It applies redirect, flush, stall and halt control so that ID always sees a clean instruction stream.

---
 rtl/pc_fetch_stage_pkg.sv | 18 +
 rtl/pc_fetch_stage_ifid_reg.sv | 35 +++
 rtl/pc_fetch_stage.sv | 94 +++++++++
 tb/tb_pc_fetch_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM states, NOP/HALT encodings, PC step.
package pc_fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam logic [15:0] PC_STEP     = 16'd2;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:12] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/pc_fetch_stage_ifid_reg.sv
// IF/ID pipeline latch: flush inserts a bubble (PC fields kept), load captures a fetch, else hold.
module ifid_reg
    import pc_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [15:0] fetch_instr,
    input  logic [15:0] fetch_pc,
    input  logic [15:0] fetch_pc_plus2,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus2 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr    <= fetch_instr;
            pc       <= fetch_pc;
            pc_plus2 <= fetch_pc_plus2;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID latch.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_rdata,
    output logic [15:0] imem_addr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_seq;
    logic         load;
    logic         flush;

    assign imem_addr = pc;
    assign pc_seq    = pc + PC_STEP;

    always_comb begin
        load  = 1'b0;
        flush = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (pc_src) flush = 1'b1;
                    else        load  = 1'b1;
                end
            end
            default: flush = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            state  <= BOOT;
            halted <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
                RUN: begin
                    // Stall outranks redirect: comparator operands are stale while stalled.
                    if (!stall) begin
                        if (pc_src) begin
                            pc <= branch_target & 16'hFFFE;
                        end else begin
                            pc <= pc_seq;
                            if (is_halt(imem_rdata)) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    ifid_reg u_ifid (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .flush          (flush),
        .fetch_instr    (imem_rdata),
        .fetch_pc       (pc),
        .fetch_pc_plus2 (pc_seq),
        .instr          (ifid_instr),
        .pc             (ifid_pc),
        .pc_plus2       (ifid_pc_plus2),
        .valid          (ifid_valid)
    );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed vector table plus randomized run against a reference model.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] imem_rdata;
    logic [15:0] imem_addr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    logic [15:0] mem [0:32767];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[15:1]];

    pc_fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    typedef struct {
        logic        st;
        logic        src;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] p2;
        logic        valid;
        logic        hlt;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(input logic st, input logic src, input logic [15:0] tgt,
                                input logic [15:0] addr, input logic [15:0] instr,
                                input logic [15:0] pc, input logic [15:0] p2,
                                input logic valid, input logic hlt);
        vec_t v;
        v.st = st; v.src = src; v.tgt = tgt; v.addr = addr; v.instr = instr;
        v.pc = pc; v.p2 = p2; v.valid = valid; v.hlt = hlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                           input logic [15:0] pc, input logic [15:0] p2,
                           input logic valid, input logic hlt);
        chk({tag, ".imem_addr"}, imem_addr, addr);
        chk({tag, ".ifid_instr"}, ifid_instr, instr);
        chk({tag, ".ifid_pc"}, ifid_pc, pc);
        chk({tag, ".ifid_pc_plus2"}, ifid_pc_plus2, p2);
        chk({tag, ".ifid_valid"}, {15'd0, ifid_valid}, {15'd0, valid});
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
    endtask

    task automatic step(input logic st, input logic src, input logic [15:0] tgt);
        stall = st;
        pc_src = src;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted a few ns after an edge, released on a falling edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        stall = 1'b0;
        pc_src = 1'b0;
        #1;
        chk_all(tag, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: architectural view of the fetch stage.
    logic        m_booted, m_halted, m_valid;
    int unsigned m_pc, m_id_pc, m_id_p2;
    logic [15:0] m_instr;

    task automatic model_reset();
        m_booted = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
        m_pc = 0; m_id_pc = 0; m_id_p2 = 0; m_instr = 16'h0000;
    endtask

    task automatic model_step(input logic st, input logic src, input logic [15:0] tgt);
        logic [15:0] word;
        word = mem[m_pc / 2];
        if (!m_booted) begin
            m_booted = 1'b1;
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (m_halted) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (src) begin
            m_pc = int'(tgt) - (int'(tgt) % 2);
            m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = word;
            m_id_pc = m_pc;
            m_id_p2 = (m_pc + 2) % 65536;
            m_valid = 1'b1;
            m_pc = (m_pc + 2) % 65536;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
        end
    endtask

    initial begin
        int unsigned halt_cycles;
        logic [15:0] w;

        for (int i = 0; i < 32768; i++) mem[i] = {4'h1, 12'(i * 2)};
        mem[0]     = 16'h1234;
        mem[16'h10] = 16'hF000;
        mem[16'h21] = 16'hF042;

        //          st    src   tgt       addr      instr     pc        p2        vld   hlt
        vt[0]  = mk(1'b1, 1'b1, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0);
        vt[2]  = mk(1'b0, 1'b0, 16'h0000, 16'h0004, 16'h1002, 16'h0002, 16'h0004, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 16'h0000, 16'h0006, 16'h1004, 16'h0004, 16'h0006, 1'b1, 1'b0);
        vt[4]  = mk(1'b0, 1'b0, 16'h0000, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1'b1, 1'b0);
        vt[5]  = mk(1'b1, 1'b1, 16'h0030, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1'b1, 1'b0);
        vt[6]  = mk(1'b1, 1'b1, 16'h0030, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 16'h0000, 16'h000A, 16'h1008, 16'h0008, 16'h000A, 1'b1, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 16'h0000, 16'h000C, 16'h100A, 16'h000A, 16'h000C, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 16'h0000, 16'h000E, 16'h100C, 16'h000C, 16'h000E, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 16'h0000, 16'h0010, 16'h100E, 16'h000E, 16'h0010, 1'b1, 1'b0);
        vt[11] = mk(1'b0, 1'b1, 16'h0041, 16'h0040, 16'h0000, 16'h000E, 16'h0010, 1'b0, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 16'h0000, 16'h0042, 16'h1040, 16'h0040, 16'h0042, 1'b1, 1'b0);
        vt[13] = mk(1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0040, 16'h0042, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1FFE, 16'hFFFE, 16'h0000, 1'b1, 1'b0);
        vt[15] = mk(1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0);
        vt[16] = mk(1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0);
        vt[17] = mk(1'b0, 1'b0, 16'h0000, 16'h0022, 16'hF000, 16'h0020, 16'h0022, 1'b1, 1'b1);
        vt[18] = mk(1'b0, 1'b1, 16'h0010, 16'h0022, 16'h0000, 16'h0020, 16'h0022, 1'b0, 1'b1);
        vt[19] = mk(1'b1, 1'b0, 16'h0000, 16'h0022, 16'h0000, 16'h0020, 16'h0022, 1'b0, 1'b1);

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vt[i].st, vt[i].src, vt[i].tgt);
            chk_all($sformatf("vec%0d", i), vt[i].addr, vt[i].instr, vt[i].pc, vt[i].p2,
                    vt[i].valid, vt[i].hlt);
        end

        // Asynchronous reset while halted, then fetch resumes from address 0
        do_reset("async_halt");
        step(1'b0, 1'b0, 16'h0000);
        chk_all("reboot", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000);
        chk_all("resume", 16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall
        step(1'b1, 1'b0, 16'h0000);
        do_reset("async_stall");

        // Randomized run against the reference model
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h7;
            mem[i] = w;
        end
        model_reset();
        halt_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            logic        st, src;
            logic [15:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            src = ($urandom_range(0, 4) == 0);
            tgt = 16'($urandom);
            model_step(st, src, tgt);
            step(st, src, tgt);
            chk_all("rand", 16'(m_pc), m_instr, 16'(m_id_pc), 16'(m_id_p2), m_valid, m_halted);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
                halt_cycles = 0;
                do_reset("rand_reset");
                model_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
